writeback_arb: RTL and testbench
================================

Name: writeback_arb

Overview:
- Multi-channel successor to the single-source writeback stage.
- Accepts completed results from NCH independent execution channels (e.g. ALU, load, mul/div), each over a valid/ready handshake.
- Selects at most one channel per cycle by round-robin and registers the chosen result onto the register-file write port.
- Also exports a bypass copy of the registered write and a retired-instruction counter. Sits between the memory/execute completion paths and the regfile.

Parameters:
- NCH, 3, number of completion channels (1..8).
- XLEN, 64, result data width.
- CNTW, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  NCH  per-channel result valid.
- in_ready  out  NCH  per-channel accept; a transfer occurs when in_valid[c] and in_ready[c] are both 1.
- in_rd  in  NCH*5  per-channel destination register (creg_addr_t); channel c occupies bits [5c+4:5c].
- in_wen  in  NCH  per-channel register-write enable (the channel's RegWEn).
- in_data  in  NCH*XLEN  per-channel result.
- flush  in  1  drop any registered but unwritten result this cycle.
- wa  out  5  regfile write address.
- wd  out  XLEN  regfile write data.
- wvalid  out  1  regfile write enable.
- byp_valid  out  1  bypass entry valid; equals wvalid.
- byp_rd  out  5  bypass address; equals wa.
- byp_data  out  XLEN  bypass data; equals wd.
- retired  out  CNTW  count of results accepted and not flushed.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - wvalid=0, wa=0, wd=0.
  - Round-robin pointer = NCH-1, so channel 0 has first priority.
  - retired=0.
  - in_ready=0 while reset_n=0.
- Arbitration (combinational):
  - Search channels starting at ptr+1 mod NCH.
  - The first c with in_valid[c]=1 receives the grant; in_ready is one-hot on that channel, or all-zero if none is valid.
  - in_ready never depends on in_ready of another channel, and never asserts for an invalid channel.
  - No stall input exists: the output stage is a write port and always drains, so a grant happens every cycle any valid is high.
- Pointer update: on a grant to channel c, ptr <= c next cycle; otherwise unchanged.
- Wrap-around: with ptr=NCH-1 the search starts at channel 0.
- Output register (1-cycle latency):
  - On a grant: wa <= in_rd[c], wd <= in_data[c], wvalid <= in_wen[c] && (in_rd[c] != 0).
  - x0 writes are suppressed: wvalid=0, but wa and wd still load.
  - With no grant: wvalid <= 0; wa and wd hold their values.
- flush:
  - flush=1 forces wvalid <= 0 next cycle.
  - A grant in the same cycle is still handshaken: in_ready stays asserted and the channel's result is consumed and discarded.
  - The pointer still advances; retired does not increment.
- retired:
  - Increments by 1 on each granted transfer with flush=0, regardless of wen or rd.
  - Wraps modulo 2^CNTW.
- Channel inputs must hold stable while in_valid is high and in_ready is low; the block never latches unhandshaken data.
- Reset deasserted mid-stream: the first cycle after release arbitrates normally from channel 0.
- Single-channel build (NCH=1): in_ready = in_valid; the pointer is constant.

Decomposition:
- Shared package (pipes) gains:
  - typedef wb_req_t {creg_addr_t rd; u1 wen; u64 data;};
  - typedef wb_port_t {creg_addr_t wa; u64 wd; u1 wvalid;};
  - localparam WB_NCH=3.
- One sub-module: rr_arbiter (parameter N; inputs req[N] and ptr; outputs one-hot grant and grant index). Reusable by later multi-issue stages.

Test Plan:
- Reset then idle: reset_n=0 mid-cycle → outputs read 0 immediately (asynchronous); after release with all in_valid=0 → wvalid=0, retired=0, in_ready=0.
- Single write: ch1 valid, rd=5, wen=1, data=0xDEAD → in_ready=3'b010 that cycle; next cycle wa=5, wd=0xDEAD, wvalid=1, byp_* identical; retired=1.
- Fairness and wrap: all 3 channels held valid for 6 cycles → grants in order 0,1,2,0,1,2; retired=6.
- x0 suppression: ch0 rd=0, wen=1, data=0x55 → next cycle wvalid=0, wa=0, wd=0x55; retired increments.
- No-write retire: ch2 wen=0, rd=7 → wvalid=0 next cycle; retired increments.
- Flush collision: ch0 valid (rd=3) with flush=1 in the same cycle → in_ready[0]=1; next cycle wvalid=0, retired unchanged; the next request is granted to ch1 first.

Source files
------------

// File: rtl/pipes.sv
// Shared pipeline types for the completion and writeback paths.
// Register addresses, write-port bundles and the default channel count.
package pipes;

  typedef logic        u1;
  typedef logic [63:0] u64;
  typedef logic [4:0]  creg_addr_t;

  typedef struct packed {
    creg_addr_t rd;
    u1          wen;
    u64         data;
  } wb_req_t;

  typedef struct packed {
    creg_addr_t wa;
    u64         wd;
    u1          wvalid;
  } wb_port_t;

  localparam int WB_NCH = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 (mod N) and grants
// the first requester, returning a one-hot grant and its index.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic found;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise a latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found                         = 1'b1;
        grant[(int'(ptr) + i) % N]    = 1'b1;
        grant_idx                     = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/writeback_arb.sv
// Writeback arbiter: picks one completed result per cycle by round-robin and
// registers it onto the regfile write port, with a bypass copy and retire count.
module writeback_arb
  import pipes::*;
#(
  parameter int NCH  = WB_NCH,
  parameter int XLEN = 64,
  parameter int CNTW = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NCH-1:0]      in_valid,
  output logic [NCH-1:0]      in_ready,
  input  logic [NCH*5-1:0]    in_rd,
  input  logic [NCH-1:0]      in_wen,
  input  logic [NCH*XLEN-1:0] in_data,
  input  logic                flush,
  output logic [4:0]          wa,
  output logic [XLEN-1:0]     wd,
  output logic                wvalid,
  output logic                byp_valid,
  output logic [4:0]          byp_rd,
  output logic [XLEN-1:0]     byp_data,
  output logic [CNTW-1:0]     retired
);

  localparam int PTRW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PTRW-1:0] ptr_q, ptr_d;
  creg_addr_t      wa_q, wa_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic            wvalid_q, wvalid_d;
  logic [CNTW-1:0] retired_q, retired_d;

  logic [NCH-1:0]  grant;
  logic [PTRW-1:0] grant_idx;
  logic            any_grant;

  rr_arbiter #(.N(NCH), .IW(PTRW)) u_rr (
    .req       (in_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Handshake is held off entirely while reset is asserted.
  assign in_ready  = grant & {NCH{reset_n}};
  assign any_grant = |in_ready;

  always_comb begin
    ptr_d     = ptr_q;
    wa_d      = wa_q;
    wd_d      = wd_q;
    wvalid_d  = 1'b0;
    retired_d = retired_q;
    if (any_grant) begin
      ptr_d    = grant_idx;
      wa_d     = in_rd[int'(grant_idx)*5 +: 5];
      wd_d     = in_data[int'(grant_idx)*XLEN +: XLEN];
      // x0 writes still load address/data but never raise the write enable;
      // a flushed grant is consumed and discarded.
      wvalid_d = in_wen[grant_idx] && (wa_d != '0) && !flush;
      if (!flush) retired_d = retired_q + CNTW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // update together at the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= PTRW'(NCH - 1);
      wa_q      <= '0;
      wd_q      <= '0;
      wvalid_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      wvalid_q  <= wvalid_d;
      retired_q <= retired_d;
    end
  end

  assign wa        = wa_q;
  assign wd        = wd_q;
  assign wvalid    = wvalid_q;
  assign byp_valid = wvalid_q;
  assign byp_rd    = wa_q;
  assign byp_data  = wd_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_writeback_arb.sv
// Directed self-checking bench for writeback_arb (NCH=3, XLEN=64, CNTW=64).
module tb_writeback_arb;

  localparam int NCH  = 3;
  localparam int XLEN = 64;
  localparam int CNTW = 64;

  logic                clk;
  logic                reset_n;
  logic [NCH-1:0]      in_valid;
  logic [NCH-1:0]      in_ready;
  logic [NCH*5-1:0]    in_rd;
  logic [NCH-1:0]      in_wen;
  logic [NCH*XLEN-1:0] in_data;
  logic                flush;
  logic [4:0]          wa;
  logic [XLEN-1:0]     wd;
  logic                wvalid;
  logic                byp_valid;
  logic [4:0]          byp_rd;
  logic [XLEN-1:0]     byp_data;
  logic [CNTW-1:0]     retired;

  int total = 0;
  int bad   = 0;

  writeback_arb #(.NCH(NCH), .XLEN(XLEN), .CNTW(CNTW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_wen    (in_wen),
    .in_data   (in_data),
    .flush     (flush),
    .wa        (wa),
    .wd        (wd),
    .wvalid    (wvalid),
    .byp_valid (byp_valid),
    .byp_rd    (byp_rd),
    .byp_data  (byp_data),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are read here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic v, input logic [4:0] rd,
                        input logic wen, input logic [63:0] data);
    in_valid[c]           = v;
    in_rd[c*5 +: 5]       = rd;
    in_wen[c]             = wen;
    in_data[c*XLEN +: XLEN] = data;
  endtask

  task automatic clear_all();
    in_valid = '0;
    in_rd    = '0;
    in_wen   = '0;
    in_data  = '0;
    flush    = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  logic [2:0]  exp_ready [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [4:0]  exp_wa    [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
  logic [63:0] exp_wd    [6] = '{64'hA0, 64'hA1, 64'hA2, 64'hA0, 64'hA1, 64'hA2};

  initial begin
    reset_n = 1'b1;
    clear_all();

    // Asynchronous reset asserted mid-cycle with all channels requesting.
    in_valid = 3'b111;
    #3 reset_n = 1'b0;
    #1;
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_wa", 64'(wa), 64'd0);
    check("rst_wd", wd, 64'd0);
    check("rst_retired", retired, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    clear_all();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("idle_wvalid", 64'(wvalid), 64'd0);
    check("idle_retired", retired, 64'd0);
    check("idle_in_ready", 64'(in_ready), 64'd0);

    // Single write from channel 1.
    set_ch(1, 1'b1, 5'd5, 1'b1, 64'hDEAD);
    #1;
    check("single_ready", 64'(in_ready), 64'b010);
    tick();
    clear_all();
    check("single_wa", 64'(wa), 64'd5);
    check("single_wd", wd, 64'hDEAD);
    check("single_wvalid", 64'(wvalid), 64'd1);
    check("single_byp_valid", 64'(byp_valid), 64'd1);
    check("single_byp_rd", 64'(byp_rd), 64'd5);
    check("single_byp_data", byp_data, 64'hDEAD);
    check("single_retired", retired, 64'd1);

    // Idle cycle: write enable drops, address/data hold.
    tick();
    check("hold_wvalid", 64'(wvalid), 64'd0);
    check("hold_wa", 64'(wa), 64'd5);
    check("hold_wd", wd, 64'hDEAD);

    // Fairness and wrap from a fresh reset: all channels held valid.
    do_reset();
    set_ch(0, 1'b1, 5'd1, 1'b1, 64'hA0);
    set_ch(1, 1'b1, 5'd2, 1'b1, 64'hA1);
    set_ch(2, 1'b1, 5'd3, 1'b1, 64'hA2);
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("rr_ready_%0d", i), 64'(in_ready), 64'(exp_ready[i]));
      tick();
      check($sformatf("rr_wa_%0d", i), 64'(wa), 64'(exp_wa[i]));
      check($sformatf("rr_wd_%0d", i), wd, exp_wd[i]);
      check($sformatf("rr_wvalid_%0d", i), 64'(wvalid), 64'd1);
    end
    clear_all();
    check("rr_retired", retired, 64'd6);

    // x0 suppression on channel 0 (pointer at 2, so search starts at 0).
    set_ch(0, 1'b1, 5'd0, 1'b1, 64'h55);
    #1;
    check("x0_ready", 64'(in_ready), 64'b001);
    tick();
    clear_all();
    check("x0_wvalid", 64'(wvalid), 64'd0);
    check("x0_wa", 64'(wa), 64'd0);
    check("x0_wd", wd, 64'h55);
    check("x0_retired", retired, 64'd7);

    // Retire without a register write on channel 2.
    set_ch(2, 1'b1, 5'd7, 1'b0, 64'h77);
    #1;
    check("nowen_ready", 64'(in_ready), 64'b100);
    tick();
    clear_all();
    check("nowen_wvalid", 64'(wvalid), 64'd0);
    check("nowen_wa", 64'(wa), 64'd7);
    check("nowen_retired", retired, 64'd8);

    // Flush collides with a grant to channel 0.
    set_ch(0, 1'b1, 5'd3, 1'b1, 64'h33);
    flush = 1'b1;
    #1;
    check("flush_ready", 64'(in_ready), 64'b001);
    tick();
    clear_all();
    check("flush_wvalid", 64'(wvalid), 64'd0);
    check("flush_retired", retired, 64'd8);

    // Pointer advanced past channel 0 despite the flush.
    set_ch(0, 1'b1, 5'd9, 1'b1, 64'h90);
    set_ch(1, 1'b1, 5'd10, 1'b1, 64'h91);
    #1;
    check("post_flush_ready", 64'(in_ready), 64'b010);
    tick();
    clear_all();
    check("post_flush_wa", 64'(wa), 64'd10);
    check("post_flush_wd", wd, 64'h91);
    check("post_flush_wvalid", 64'(wvalid), 64'd1);
    check("post_flush_retired", retired, 64'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
